// File: rtl/tt_check_pkg.sv
// Shared state encoding and width helpers for the truth-table checker.
// Combinational helpers only; no latency, no flow control.
package tt_check_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // fail_count must hold 2^n_in, the count when every vector mismatches.
    function automatic int fail_cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int settle_cnt_w(input int settle_cycles);
        return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired_o is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a combinational DUT and checks its output against EXPECTED.
// One vector per SETTLE_CYCLES+1 cycles; start ignored while busy, abort cancels a sweep.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                  N_IN          = 3,
    parameter logic [2**N_IN-1:0]  EXPECTED      = 8'b1000_0000,
    parameter int                  SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic [N_IN-1:0]               dut_in,
    input  logic                          dut_out,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [fail_cnt_w(N_IN)-1:0]   fail_count,
    output logic                          first_fail_valid,
    output logic [N_IN-1:0]               first_fail_vec
);

    localparam int FW = fail_cnt_w(N_IN);
    localparam int CW = settle_cnt_w(SETTLE_CYCLES);
    // The SETTLE cycle that sees the counter at zero is the last one, hence S-1.
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            pass_q, pass_d;
    logic            timer_load;
    logic            timer_expired;
    logic            exp_bit;
    logic            mismatch;

    settle_timer #(.W(CW)) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (state_q == SETTLE),
        .expired_o  (timer_expired)
    );

    assign exp_bit  = EXPECTED[vec_q];
    // Case inequality so an X or Z from the DUT is reported rather than masked.
    assign mismatch = (dut_out !== exp_bit);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        fail_d     = fail_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    vec_d      = '0;
                    fail_d     = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else begin
                    if (mismatch) begin
                        fail_d = fail_q + FW'(1);
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        pass_d  = (fail_d == '0);
                    end else begin
                        state_d    = SETTLE;
                        vec_d      = vec_q + N_IN'(1);
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_in           = vec_q;
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking stimulus/response engine for small combinational blocks. It drives every input combination into a DUT, waits a programmable settle time, samples the DUT output, and compares it against an expected truth table supplied as a parameter. It reports pass/fail, a mismatch count and the first failing vector. It sits beside a combinational block under test on the board or in a top-level wrapper, and does in hardware the check that our benches do in simulation.

## Interface
- `N_IN`, default 3: number of DUT inputs; vectors are swept from 0 to 2^N_IN-1.
- `EXPECTED`, default 8'b1000_0000: expected output, one bit per vector; bit k is the expected F for `dut_in == k`.
- `SETTLE_CYCLES`, default 2: cycles `dut_in` is held before sampling; must be ≥1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a sweep; sampled only in IDLE.
- `abort` input 1: cancels a sweep in progress; ignored in IDLE.
- `dut_in` output N_IN: vector driven to the DUT; MSB maps to A, LSB maps to C.
- `dut_out` input 1: DUT output F.
- `busy` output 1: high in SETTLE and SAMPLE.
- `done` output 1: one-cycle pulse when a sweep completes.
- `pass` output 1: high when the last completed sweep had zero mismatches.
- `fail_count` output N_IN+1: number of mismatching vectors in the current or last sweep.
- `first_fail_valid` output 1: high when at least one mismatch has been recorded.
- `first_fail_vec` output N_IN: lowest vector that mismatched.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with `start`=1:
  - go to SETTLE;
  - set `dut_in`=0, settle counter=0;
  - clear `fail_count`, `pass`, `first_fail_valid` and `first_fail_vec`.
- SETTLE: increment the settle counter each cycle; after SETTLE_CYCLES cycles go to SAMPLE.
- SAMPLE:
  - A mismatch is `dut_out` != `EXPECTED[dut_in]`. An X or Z on `dut_out` also counts as a mismatch.
  - On a mismatch, increment `fail_count`.
  - On the first mismatch, also latch `first_fail_vec`=`dut_in` and set `first_fail_valid`.
  - If `dut_in` is the all-ones vector, go to DONE. Otherwise increment `dut_in`, clear the settle counter and go to SETTLE.
- `dut_in` never wraps during a sweep. The increment from the all-ones vector does not occur.
- DONE:
  - `done`=1 for exactly this cycle;
  - `pass` = (`fail_count` after the final update == 0);
  - return to IDLE.
- Results hold in IDLE until the next accepted `start`.
- `start` while busy or in DONE: ignored.
- `abort` in SETTLE or SAMPLE:
  - go to IDLE next cycle;
  - no `done` pulse, `pass` stays 0;
  - the partial `fail_count` and first-fail fields are retained;
  - `dut_in` returns to 0.
  - If `abort` and the final SAMPLE coincide, `abort` wins.
- `rst_n` low, including mid-sweep, immediately forces IDLE and sets every output to 0: `dut_in`, `busy`, `done`, `pass`, `fail_count`, `first_fail_valid`, `first_fail_vec`.

## Timing
- Cycle 0 is the edge on which `start` is sampled high in IDLE.
- `dut_in`=k is valid from cycle k·(S+1)+1. Vector k is sampled at cycle (k+1)·(S+1), where S = SETTLE_CYCLES.
- `done` is high in cycle 2^N_IN·(S+1)+1. With the defaults this is cycle 25.
- `busy` is high for cycles 1 through 2^N_IN·(S+1).
- `fail_count` and the first-fail fields update on the cycle after the failing SAMPLE. `pass` is valid together with `done`.
- The earliest next `start` is accepted in the cycle after `done`.

## Structure
- Shared package `tt_check_pkg`:
  - state encoding constants: IDLE, SETTLE, SAMPLE, DONE;
  - a width helper for `fail_count` (N_IN+1) and for the settle counter (clog2 of SETTLE_CYCLES+1).
- One natural sub-module, `settle_timer`: a loadable down-counter with a `expired` output, instanced once. The comparison, FSM and result registers stay in the top module.

## Test plan
- DUT = A&B&C, defaults, `start` pulse at cycle 0 → `done` at cycle 25, `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- DUT output tied to 0 → `pass`=0, `fail_count`=1, `first_fail_vec`=3'b111, `first_fail_valid`=1.
- DUT = ~(A&B&C) → `fail_count`=8, `first_fail_vec`=3'b000.
- `start` re-pulsed at cycle 5; `abort` at cycle 10 → second `start` has no effect; `busy` falls at cycle 11; no `done` pulse; `dut_in`=0.
- `rst_n` asserted asynchronously mid-cycle 12 → all outputs 0 before the next edge; a fresh `start` after release runs a full 25-cycle sweep.
- SETTLE_CYCLES=1 with an AND3 DUT → `done` at cycle 17 and `pass`=1. Separately, `dut_out` forced to X on vector 5 → `fail_count`=1, `first_fail_vec`=3'b101.
